// File: rtl/pref_issue_queue_if.sv
// L2 prefetch request port: block-aligned address with a valid/ready handshake.
// The queue drives it through the master modport; the L2 side uses the slave modport.
interface pref_issue_queue_if #(
  parameter int unsigned ADDR_SIZE = 64
);
  logic [ADDR_SIZE-1:0] req_addr;
  logic                 req_valid;
  logic                 req_ready;

  modport master (output req_addr, output req_valid, input req_ready);
  modport slave  (input req_addr, input req_valid, output req_ready);
endinterface

// File: rtl/pref_issue_queue.sv
// In-order prefetch issue queue. Filters redundant candidates against the queue, the recent-issue
// history and same-cycle duplicates, issues one block per handshake, and counts every drop.
module pref_issue_queue #(
  parameter int unsigned ADDR_SIZE       = 64,
  parameter int unsigned LOG2_BLOCK_SIZE = 6,
  parameter int unsigned QUEUE_DEPTH     = 8,
  parameter int unsigned RECENT_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_SIZE-1:0]          pref_addr1_i,
  input  logic                          pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]          pref_addr2_i,
  input  logic                          pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]          pref_addr3_i,
  input  logic                          pref_valid3_i,
  input  logic                          flush_i,
  pref_issue_queue_if.master            req,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy_o,
  output logic [15:0]                   drop_count_o
);
  localparam int unsigned BlkW  = ADDR_SIZE - LOG2_BLOCK_SIZE;
  localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned HistW = (RECENT_DEPTH > 1) ? $clog2(RECENT_DEPTH) : 1;

  logic [BlkW-1:0]         fifo_q [QUEUE_DEPTH];
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]         occ_q, occ_d;
  logic [BlkW-1:0]         hist_q [RECENT_DEPTH];
  logic [RECENT_DEPTH-1:0] hist_vld_q;
  logic [HistW-1:0]        hist_ptr_q;
  logic [15:0]             drop_q, drop_d;

  logic [BlkW-1:0]        cand_blk [3];
  logic [2:0]             cand_vld;
  logic [QUEUE_DEPTH-1:0] live;
  logic                   pop;
  logic [OccW-1:0]        free;
  logic [1:0]             n_acc, n_drop;
  logic [2:0]             acc;
  logic [PtrW-1:0]        slot [3];
  logic                   dup;
  logic [16:0]            drop_sum;
  logic                   unused_low_bits;

  assign cand_blk[0] = pref_addr1_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_blk[1] = pref_addr2_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_blk[2] = pref_addr3_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_vld    = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign unused_low_bits = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0], pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                             pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      live[i] = {1'b0, PtrW'(i) - rd_ptr_q} < occ_q;
    end
  end

  always_comb begin
    pop    = (occ_q != '0) && req.req_ready && !flush_i;
    free   = OccW'(QUEUE_DEPTH) - occ_q + OccW'(pop);
    n_acc  = '0;
    n_drop = '0;
    acc    = '0;
    dup    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      slot[k] = wr_ptr_q + PtrW'(n_acc);
      dup     = 1'b0;
      // The head being popped this cycle is still live here, so it still filters.
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (live[i] && fifo_q[i] == cand_blk[k]) dup = 1'b1;
      end
      for (int j = 0; j < RECENT_DEPTH; j++) begin
        if (hist_vld_q[j] && hist_q[j] == cand_blk[k]) dup = 1'b1;
      end
      for (int m = 0; m < k; m++) begin
        if (acc[m] && cand_blk[m] == cand_blk[k]) dup = 1'b1;
      end
      if (cand_vld[k] && !flush_i) begin
        if (!dup && (OccW'(n_acc) < free)) begin
          acc[k] = 1'b1;
          n_acc  = 2'(n_acc + 2'd1);
        end else begin
          n_drop = 2'(n_drop + 2'd1);
        end
      end
    end

    if (flush_i) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      occ_d    = occ_q - OccW'(pop) + OccW'(n_acc);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(n_acc);
    end

    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      hist_vld_q <= '0;
      hist_ptr_q <= '0;
      drop_q     <= '0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      drop_q   <= drop_d;
      if (pop) begin
        hist_vld_q[hist_ptr_q] <= 1'b1;
        hist_ptr_q <= (hist_ptr_q == HistW'(RECENT_DEPTH - 1)) ? '0 : hist_ptr_q + HistW'(1);
      end
    end
  end

  // Storage arrays need no reset: liveness and history validity gate every use.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (acc[k]) fifo_q[slot[k]] <= cand_blk[k];
    end
    if (pop) hist_q[hist_ptr_q] <= fifo_q[rd_ptr_q];
  end

  assign req.req_valid = (occ_q != '0);
  assign req.req_addr  = (occ_q != '0) ? {fifo_q[rd_ptr_q], {LOG2_BLOCK_SIZE{1'b0}}} : '0;
  assign occupancy_o   = occ_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Directed bench for pref_issue_queue: filtering, issue handshake, overflow, flush and async reset.
module tb_pref_issue_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a1, a2, a3;
  logic        v1, v2, v3;
  logic        flush;
  logic [3:0]  occ;
  logic [15:0] drops;
  int          tests  = 0;
  int          failed = 0;

  pref_issue_queue_if #(.ADDR_SIZE(64)) req_if ();

  pref_issue_queue #(
    .ADDR_SIZE(64), .LOG2_BLOCK_SIZE(6), .QUEUE_DEPTH(8), .RECENT_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(a1), .pref_valid1_i(v1),
    .pref_addr2_i(a2), .pref_valid2_i(v2),
    .pref_addr3_i(a3), .pref_valid3_i(v3),
    .flush_i(flush), .req(req_if),
    .occupancy_o(occ), .drop_count_o(drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cands(input logic x1, input logic [63:0] y1, input logic x2,
                       input logic [63:0] y2, input logic x3, input logic [63:0] y3);
    v1 = x1; a1 = y1; v2 = x2; a2 = y2; v3 = x3; a3 = y3;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_if.req_ready = 1'b0;
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    #12 rst = 1'b0;
    check("reset_valid", 64'(req_if.req_valid), 64'd0);
    check("reset_addr", req_if.req_addr, 64'd0);
    check("reset_occ", 64'(occ), 64'd0);

    // Single issue
    req_if.req_ready = 1'b1;
    cands(1, 64'h1040, 0, 64'h0, 0, 64'h0);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("single_valid", 64'(req_if.req_valid), 64'd1);
    check("single_addr", req_if.req_addr, 64'h1040);
    check("single_occ", 64'(occ), 64'd1);
    step();
    check("single_popped", 64'(occ), 64'd0);
    check("single_valid_low", 64'(req_if.req_valid), 64'd0);

    // Alignment and same-cycle dedup
    req_if.req_ready = 1'b0;
    cands(1, 64'h2005, 1, 64'h2030, 1, 64'h2080);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("align_occ", 64'(occ), 64'd2);
    check("align_drop", 64'(drops), 64'd1);
    check("align_addr", req_if.req_addr, 64'h2000);
    req_if.req_ready = 1'b1;
    step();
    check("align_second", req_if.req_addr, 64'h2080);
    step();
    check("align_empty", 64'(occ), 64'd0);

    // History filter and eviction
    cands(1, 64'h3000, 0, 64'h0, 0, 64'h0);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    step();
    cands(1, 64'h3000, 0, 64'h0, 0, 64'h0);
    step();
    check("hist_drop_occ", 64'(occ), 64'd0);
    check("hist_drop_cnt", 64'(drops), 64'd2);
    for (int i = 0; i < 16; i++) begin
      cands(1, 64'h10000 + 64'(i) * 64'h40, 0, 64'h0, 0, 64'h0);
      step();
    end
    check("hist_stream_occ", 64'(occ), 64'd1);
    check("hist_stream_drop", 64'(drops), 64'd2);
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    step();
    cands(1, 64'h3000, 0, 64'h0, 0, 64'h0);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("hist_evicted_occ", 64'(occ), 64'd1);
    check("hist_evicted_addr", req_if.req_addr, 64'h3000);
    check("hist_evicted_drop", 64'(drops), 64'd2);
    step();
    check("hist_evicted_pop", 64'(occ), 64'd0);

    // Overflow with simultaneous pop
    req_if.req_ready = 1'b0;
    cands(1, 64'h40000, 1, 64'h40040, 1, 64'h40080);
    step();
    check("fill_occ3", 64'(occ), 64'd3);
    cands(1, 64'h400c0, 1, 64'h40100, 1, 64'h40140);
    step();
    cands(1, 64'h40180, 0, 64'h0, 0, 64'h0);
    step();
    check("fill_occ7", 64'(occ), 64'd7);
    req_if.req_ready = 1'b1;
    cands(1, 64'h50000, 1, 64'h50040, 1, 64'h50080);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("ovf_occ", 64'(occ), 64'd8);
    check("ovf_drop", 64'(drops), 64'd3);
    check("ovf_head", req_if.req_addr, 64'h40040);

    // Backpressure stability
    req_if.req_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_addr", req_if.req_addr, 64'h40040);
    end
    check("bp_occ", 64'(occ), 64'd8);

    // Flush discards candidates and handshake, history untouched
    flush = 1'b1; req_if.req_ready = 1'b1;
    cands(1, 64'h60000, 0, 64'h0, 0, 64'h0);
    step();
    flush = 1'b0;
    check("flush_occ", 64'(occ), 64'd0);
    check("flush_valid", 64'(req_if.req_valid), 64'd0);
    check("flush_addr", req_if.req_addr, 64'd0);
    check("flush_drop", 64'(drops), 64'd3);
    req_if.req_ready = 1'b0;
    cands(1, 64'h40040, 0, 64'h0, 0, 64'h0);
    step();
    check("post_flush_occ", 64'(occ), 64'd1);
    check("post_flush_drop", 64'(drops), 64'd3);
    // Candidate equal to the head being popped is still a duplicate
    req_if.req_ready = 1'b1;
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("pop_head_dup_occ", 64'(occ), 64'd0);
    check("pop_head_dup_drop", 64'(drops), 64'd4);

    // Async reset mid-traffic
    req_if.req_ready = 1'b0;
    cands(1, 64'h70000, 1, 64'h70040, 1, 64'h70080);
    step();
    cands(1, 64'h700c0, 1, 64'h70100, 0, 64'h0);
    step();
    cands(0, 64'h0, 0, 64'h0, 0, 64'h0);
    check("pre_rst_occ", 64'(occ), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(req_if.req_valid), 64'd0);
    check("async_rst_occ", 64'(occ), 64'd0);
    check("async_rst_drop", 64'(drops), 64'd0);
    check("async_rst_addr", req_if.req_addr, 64'd0);
    #10 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
